pool_stream_ctrl: RTL



---
 rtl/pool_pkg.sv | 24 ++
 rtl/pool_line_buf.sv | 24 ++
 rtl/pool_stream_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pool_pkg.sv
// Shared types and helpers for the 2x2 stride-2 max-pooling stream engine.
package pool_pkg;

    localparam int POOL_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } pool_state_e;

    // Counter width for a 0..n-1 range; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Callers sign-extend narrower pixels into the 32-bit operands.
    function automatic logic signed [31:0] smax(input logic signed [31:0] a,
                                                input logic signed [31:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-width line buffer: holds the horizontal max of each pair from the even row.
module pool_line_buf #(
    parameter int DEPTH  = 12,
    parameter int DATA_W = 8,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    // No reset: every entry is rewritten on an even row before the odd row reads it.
    logic [DEPTH-1:0][DATA_W-1:0] mem;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pool_stream_ctrl.sv
// Streaming 2x2 stride-2 max-pool engine, channel-major raster input, valid/ready both sides.
// Optional build macro POOL_RELU_EN clamps negative pooled results to zero.
module pool_stream_ctrl
    import pool_pkg::*;
#(
    parameter int DATA_W   = POOL_DATA_W,
    parameter int IMG_W    = 24,
    parameter int IMG_H    = 24,
    parameter int CHANNELS = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     pool_done
);

    localparam int CW = cnt_w(IMG_W);
    localparam int RW = cnt_w(IMG_H);
    localparam int HW = cnt_w(CHANNELS);
    localparam int LD = IMG_W / 2;
    localparam int LW = cnt_w(LD);

    if ((IMG_W % 2) != 0 || IMG_W < 2) begin : g_bad_img_w
        $error("pool_stream_ctrl: IMG_W must be even and >= 2");
    end
    if ((IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_img_h
        $error("pool_stream_ctrl: IMG_H must be even and >= 2");
    end

    pool_state_e state, state_nxt;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [HW-1:0] ch;
    logic          col_last, row_last, ch_last, xfer;

    logic signed [DATA_W-1:0] p_reg, m_val, y_val, y_out, lb_rd;
    logic [LW-1:0]            lb_idx;
    logic                     lb_we, out_load;

    assign col_last = (col == CW'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));
    assign ch_last  = (ch  == HW'(CHANNELS - 1));

    // A full output register that is not draining this cycle blocks input.
    assign in_ready = (state == RUN) && !(out_valid && !out_ready);
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        pool_done = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (xfer && col_last && row_last && ch_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (!out_valid || out_ready) state_nxt = DONE;
            end
            DONE: begin
                pool_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || (state == IDLE && start)) begin
            col <= '0;
            row <= '0;
            ch  <= '0;
        end else if (xfer) begin
            if (col_last) begin
                col <= '0;
                if (row_last) begin
                    row <= '0;
                    ch  <= ch_last ? '0 : ch + 1'b1;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                p_reg <= '0;
        else if (xfer && !col[0])  p_reg <= in_data;
    end

    assign lb_idx   = LW'(col >> 1);
    assign m_val    = DATA_W'(smax(32'(p_reg), 32'(in_data)));
    assign y_val    = DATA_W'(smax(32'(m_val), 32'(lb_rd)));
    assign lb_we    = xfer && col[0] && !row[0];
    assign out_load = xfer && col[0] && row[0];

`ifdef POOL_RELU_EN
    assign y_out = y_val[DATA_W-1] ? '0 : y_val;
`else
    assign y_out = y_val;
`endif

    pool_line_buf #(
        .DEPTH  (LD),
        .DATA_W (DATA_W),
        .AW     (LW)
    ) u_line_buf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (lb_idx),
        .wdata (m_val),
        .raddr (lb_idx),
        .rdata (lb_rd)
    );

    // A reload in the same cycle as an accept keeps out_valid high with new data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (out_load) begin
            out_valid <= 1'b1;
            out_data  <= y_out;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
